// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the CPU and DMA ports,
// the arbiter, and the data memory.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  p0_req;
  logic                  p0_we;
  logic [2:0]            p0_mode;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [2:0]            p1_mode;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic [LEN_WIDTH-1:0]  p1_len;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  p1_done;

  logic [ADDR_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic                  mem_WE;
  logic [2:0]            mem_AddrMode;
  logic [DATA_WIDTH-1:0] mem_RD;

  modport slave (
    input  p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_mode, p1_addr, p1_wdata, p1_len,
    output p1_gnt, p1_rvalid, p1_rdata, p1_done,
    output mem_A, mem_WD, mem_WE, mem_AddrMode,
    input  mem_RD
  );

  modport master (
    output p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_mode, p1_addr, p1_wdata, p1_len,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_done,
    input  mem_A, mem_WD, mem_WE, mem_AddrMode,
    output mem_RD
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port data memory arbiter: CPU single beats (p0) and
// DMA bursts (p1), round-robin in IDLE, burst owns the bus.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] MODE_B  = 3'd3;
  localparam logic [2:0] MODE_BU = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [LEN_WIDTH-1:0]  cnt, cnt_nx, cnt_dec;
  logic [LEN_WIDTH-1:0]  idx, idx_nx;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic [ADDR_WIDTH-1:0] off;
  logic                  prio_p1, prio_nx;
  logic                  gnt0, gnt1, done;
  logic                  byte_mode;

  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] wd;
  logic                  we;
  logic [2:0]            mode;

  logic                  rv0, rv1;
  logic [DATA_WIDTH-1:0] rd0, rd1;

  assign byte_mode = (bus.p1_mode == MODE_B) ||
                     (bus.p1_mode == MODE_BU);
  assign off = byte_mode ? ADDR_WIDTH'(idx)
                         : (ADDR_WIDTH'(idx) << 2);
  assign cnt_dec = cnt - LEN_WIDTH'(1);

  // Arbitration, burst sequencing and next-state selection
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    base_nx  = base;
    prio_nx  = prio_p1;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.p0_req && (!bus.p1_req || !prio_p1)) begin
          gnt0    = 1'b1;
          prio_nx = 1'b1;
        end else if (bus.p1_req) begin
          gnt1     = 1'b1;
          prio_nx  = 1'b0;
          cnt_nx   = bus.p1_len;
          idx_nx   = LEN_WIDTH'(1);
          base_nx  = bus.p1_addr;
          state_nx = (bus.p1_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (bus.p1_req) begin
          gnt1   = 1'b1;
          cnt_nx = cnt_dec;
          idx_nx = idx + LEN_WIDTH'(1);
          if (cnt_dec == '0) state_nx = DONE;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory bus mux; quiet (all zero) when nothing is granted
  always_comb begin
    a    = '0;
    wd   = '0;
    we   = 1'b0;
    mode = 3'd0;
    if (gnt0) begin
      a    = bus.p0_addr;
      wd   = bus.p0_wdata;
      we   = bus.p0_we;
      mode = bus.p0_mode;
    end else if (gnt1) begin
      a    = (state == IDLE) ? bus.p1_addr : base + off;
      wd   = bus.p1_wdata;
      we   = bus.p1_we;
      mode = bus.p1_mode;
    end
  end

  // FSM, burst counters and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      base    <= '0;
      prio_p1 <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      base    <= base_nx;
      prio_p1 <= prio_nx;
    end
  end

  // Read responses: capture mem_RD one cycle after a read grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rv0 <= gnt0 && !bus.p0_we;
      rv1 <= gnt1 && !bus.p1_we;
      if (gnt0 && !bus.p0_we) rd0 <= bus.mem_RD;
      if (gnt1 && !bus.p1_we) rd1 <= bus.mem_RD;
    end
  end

  assign bus.p0_gnt       = gnt0;
  assign bus.p1_gnt       = gnt1;
  assign bus.p1_done      = done;
  assign bus.p0_rvalid    = rv0;
  assign bus.p1_rvalid    = rv1;
  assign bus.p0_rdata     = rd0;
  assign bus.p1_rdata     = rd1;
  assign bus.mem_A        = a;
  assign bus.mem_WD       = wd;
  assign bus.mem_WE       = we;
  assign bus.mem_AddrMode = mode;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(4)
  ) bus ();

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(logic [31:0] ad);
    return (ad == 32'h0001_0000) ? 32'hDEAD_BEEF
                                 : (ad ^ 32'h5A5A_1234);
  endfunction

  assign bus.mem_RD = memfn(bus.mem_A);

  function automatic int step_of(logic [2:0] md);
    return (md == 3'd3 || md == 3'd4) ? 1 : 4;
  endfunction

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        done;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] wd;
  } exp_t;

  exp_t        e;
  int          m_left;
  int          m_k;
  logic [31:0] m_base;
  bit          m_done_nx;
  bit          m_last_p0;
  bit          e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;

  function automatic void predict();
    e = '0;
    if (m_done_nx) begin
      e.done = 1'b1;
    end else if (m_left > 0) begin
      if (bus.p1_req) begin
        e.g1 = 1'b1;
        e.a  = m_base + 32'(m_k * step_of(bus.p1_mode));
      end
    end else if (bus.p0_req && (!bus.p1_req || !m_last_p0)) begin
      e.g0 = 1'b1;
      e.a  = bus.p0_addr;
    end else if (bus.p1_req) begin
      e.g1 = 1'b1;
      e.a  = bus.p1_addr;
    end
    if (e.g0) begin
      e.we = bus.p0_we; e.mode = bus.p0_mode; e.wd = bus.p0_wdata;
    end else if (e.g1) begin
      e.we = bus.p1_we; e.mode = bus.p1_mode; e.wd = bus.p1_wdata;
    end
  endfunction

  function automatic void commit();
    if (!rst_n) begin
      m_left = 0; m_k = 0; m_base = '0;
      m_done_nx = 1'b0; m_last_p0 = 1'b0;
      e_rv0 = 1'b0; e_rv1 = 1'b0;
      e_rd0 = '0; e_rd1 = '0;
      return;
    end
    e_rv0 = e.g0 && !bus.p0_we;
    e_rv1 = e.g1 && !bus.p1_we;
    if (e_rv0) e_rd0 = memfn(e.a);
    if (e_rv1) e_rd1 = memfn(e.a);
    if (m_done_nx) begin
      m_done_nx = 1'b0;
    end else if (m_left > 0) begin
      if (bus.p1_req) begin
        m_k++;
        m_left--;
        if (m_left == 0) m_done_nx = 1'b1;
      end else begin
        m_left    = 0;
        m_done_nx = 1'b1;
      end
    end else if (e.g0) begin
      m_last_p0 = 1'b1;
    end else if (e.g1) begin
      m_last_p0 = 1'b0;
      m_base    = bus.p1_addr;
      m_k       = 1;
      m_left    = int'(bus.p1_len);
      if (m_left == 0) m_done_nx = 1'b1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    #2;
    predict();
    chk("p0_gnt", 32'(bus.p0_gnt), 32'(e.g0));
    chk("p1_gnt", 32'(bus.p1_gnt), 32'(e.g1));
    chk("p1_done", 32'(bus.p1_done), 32'(e.done));
    chk("mem_WE", 32'(bus.mem_WE), 32'(e.we));
    chk("mem_mode", 32'(bus.mem_AddrMode), 32'(e.mode));
    chk("mem_A", bus.mem_A, e.a);
    chk("mem_WD", bus.mem_WD, e.wd);
    chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rv0));
    chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rv1));
    chk("p0_rdata", bus.p0_rdata, e_rd0);
    chk("p1_rdata", bus.p1_rdata, e_rd1);
  endtask

  task automatic adv();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic set_p1(logic rq, logic w, logic [2:0] md,
                        logic [31:0] ad, logic [3:0] ln);
    bus.p1_req = rq; bus.p1_we = w; bus.p1_mode = md;
    bus.p1_addr = ad; bus.p1_len = ln;
  endtask

  task automatic set_p0(logic rq, logic w, logic [2:0] md,
                        logic [31:0] ad);
    bus.p0_req = rq; bus.p0_we = w; bus.p0_mode = md;
    bus.p0_addr = ad;
  endtask

  initial begin
    logic [2:0]  hm;
    logic [31:0] ha;
    logic [3:0]  hl;
    logic        hw;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    bus.p0_wdata = '0;
    bus.p1_wdata = '0;
    e = '0;
    @(negedge clk);
    adv();
    adv();
    rst_n = 1'b1;

    // reset state
    settle();
    chk("rst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd0);
    chk("rst_done", 32'(bus.p1_done), 32'd0);
    chk("rst_rdata", bus.p0_rdata | bus.p1_rdata, 32'd0);
    adv();

    // CPU read of 0x10000, latency 1
    set_p0(1, 0, 3'd0, 32'h0001_0000);
    settle();
    chk("r26_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("r26_A", bus.mem_A, 32'h0001_0000);
    adv();
    bus.p0_req = 1'b0;
    settle();
    chk("r26_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("r26_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    adv();
    settle();
    chk("r26_rv_pulse", 32'(bus.p0_rvalid), 32'd0);
    chk("r26_hold", bus.p0_rdata, 32'hDEAD_BEEF);
    adv();

    // round robin from reset
    rst_n = 1'b0;
    settle();
    adv();
    rst_n = 1'b1;
    set_p0(1, 0, 3'd0, 32'h20);
    set_p1(1, 0, 3'd0, 32'h40, 4'd0);
    settle();
    chk("r27_first", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd2);
    adv();
    bus.p0_req = 1'b0;
    settle();
    chk("r27_second", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd1);
    chk("r27_A", bus.mem_A, 32'h40);
    adv();
    bus.p1_req = 1'b0;
    settle();
    chk("r27_done", 32'(bus.p1_done), 32'd1);
    adv();
    bus.p0_req = 1'b1;
    bus.p1_req = 1'b1;
    settle();
    chk("r27_third", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd2);
    adv();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    settle();
    adv();

    // word write burst, CPU stalled
    set_p0(1, 1, 3'd0, 32'h80);
    set_p1(1, 1, 3'd0, 32'h0001_0010, 4'd3);
    for (int k = 0; k < 4; k++) begin
      bus.p1_wdata = 32'h0000_1000 + 32'(k);
      settle();
      chk("r28_A", bus.mem_A, 32'h0001_0010 + 32'(4 * k));
      chk("r28_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd1);
      chk("r28_WD", bus.mem_WD, 32'h0000_1000 + 32'(k));
      adv();
    end
    bus.p1_req = 1'b0;
    settle();
    chk("r28_done", 32'(bus.p1_done), 32'd1);
    chk("r28_stall", 32'(bus.p0_gnt), 32'd0);
    adv();
    settle();
    chk("r28_done_once", 32'(bus.p1_done), 32'd0);
    chk("r28_p0_after", 32'(bus.p0_gnt), 32'd1);
    adv();
    bus.p0_req = 1'b0;

    // byte burst wrapping past the top of memory
    set_p1(1, 0, 3'd3, 32'hFFFF_FFFF, 4'd1);
    settle();
    chk("r29_A0", bus.mem_A, 32'hFFFF_FFFF);
    adv();
    settle();
    chk("r29_A1", bus.mem_A, 32'h0000_0000);
    chk("r29_rd0", bus.p1_rdata, 32'hFFFF_FFFF ^ 32'h5A5A_1234);
    adv();
    bus.p1_req = 1'b0;
    settle();
    chk("r29_done", 32'(bus.p1_done), 32'd1);
    adv();

    // abort by dropping p1_req after beat 1
    set_p1(1, 0, 3'd0, 32'h100, 4'd3);
    settle();
    adv();
    settle();
    chk("r30_beat1", bus.mem_A, 32'h104);
    adv();
    bus.p1_req = 1'b0;
    settle();
    chk("r30_nobeat", 32'({bus.p1_gnt, bus.p1_done}), 32'd0);
    adv();
    settle();
    chk("r30_done", 32'(bus.p1_done), 32'd1);
    adv();
    bus.p0_req = 1'b1;
    bus.p0_we  = 1'b0;
    settle();
    chk("r30_idle", 32'({bus.p0_gnt, bus.p1_done}), 32'd2);
    adv();
    bus.p0_req = 1'b0;

    // reset in the middle of a burst
    set_p1(1, 0, 3'd0, 32'h200, 4'd3);
    settle();
    adv();
    settle();
    adv();
    rst_n = 1'b0;
    settle();
    adv();
    rst_n = 1'b1;
    bus.p0_req = 1'b1;
    settle();
    chk("r30_rst_done", 32'(bus.p1_done), 32'd0);
    chk("r30_rst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd2);
    adv();
    set_p0(0, 0, 0, 0);
    bus.p1_req = 1'b0;
    settle();
    chk("r30_rst_nodone", 32'(bus.p1_done), 32'd0);
    adv();

    // random traffic
    hm = 3'd0; ha = '0; hl = '0; hw = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(99) != 0);
      bus.p0_req   = ($urandom_range(2) != 0);
      bus.p0_we    = 1'($urandom_range(1));
      bus.p0_mode  = 3'($urandom_range(4));
      bus.p0_addr  = $urandom;
      bus.p0_wdata = $urandom;
      bus.p1_wdata = $urandom;
      if (m_left > 0 && !m_done_nx) begin
        bus.p1_req = ($urandom_range(15) != 0);
      end else begin
        bus.p1_req = ($urandom_range(2) == 0);
        hm = 3'($urandom_range(4));
        hl = 4'($urandom_range(15));
        hw = 1'($urandom_range(1));
        ha = ($urandom_range(1) == 1)
           ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
           : $urandom;
      end
      bus.p1_mode = hm;
      bus.p1_len  = hl;
      bus.p1_we   = hw;
      bus.p1_addr = ha;
      settle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
